// File: rtl/jtvigil_pkg.sv
// Shared definitions for the ROM arbiter: default word offsets, FSM states
// and the round-robin requester order.
package jtvigil_pkg;

   localparam logic [21:0] SCR1_OFFSET_DEF = 22'h00000;
   localparam logic [21:0] SCR2_OFFSET_DEF = 22'h08000;
   localparam logic [21:0] OBJ_OFFSET_DEF  = 22'h10000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT
   } state_e;

   typedef enum logic [1:0] {
      SRC_SCR1,
      SRC_SCR2,
      SRC_OBJ
   } src_e;

   function automatic src_e src_next(input src_e s);
      case (s)
         SRC_SCR1: return SRC_SCR2;
         SRC_SCR2: return SRC_OBJ;
         default:  return SRC_SCR1;
      endcase
   endfunction

   // First pending requester found walking scr1 -> scr2 -> obj from start.
   function automatic src_e rr_pick(input logic [2:0] pend, input src_e start);
      src_e s;
      src_e pick;
      logic found;
      s     = start;
      pick  = start;
      found = 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
         if (!found && pend[s]) begin
            pick  = s;
            found = 1'b1;
         end
         s = src_next(s);
      end
      return pick;
   endfunction

endpackage

// File: rtl/jtvigil_rom_cache.sv
// One-entry read cache for a single ROM requester: tag, data word, valid bit.
module jtvigil_rom_cache #(
   parameter int unsigned AW = 17
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cs,
   input  logic [AW-1:0] addr,
   input  logic          fill,
   input  logic [AW-1:0] fill_tag,
   input  logic [31:0]   fill_data,
   output logic          ok,
   output logic          miss,
   output logic [31:0]   data
);

   logic          valid_q, valid_d;
   logic [AW-1:0] tag_q, tag_d;
   logic [31:0]   data_q, data_d;
   logic          hit;

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (fill) begin
         valid_d = 1'b1;
         tag_d   = fill_tag;
         data_d  = fill_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
      end
   end

   assign hit  = valid_q && (tag_q == addr);
   assign ok   = cs && hit;
   assign miss = cs && !hit;
   assign data = data_q;

endmodule

// File: rtl/jtvigil_rom_arb.sv
// Round-robin arbiter giving three cached ROM requesters access to a single
// request/grant/valid memory port, one access outstanding at a time.
module jtvigil_rom_arb
   import jtvigil_pkg::*;
#(
   parameter logic [21:0] SCR1_OFFSET = SCR1_OFFSET_DEF,
   parameter logic [21:0] SCR2_OFFSET = SCR2_OFFSET_DEF,
   parameter logic [21:0] OBJ_OFFSET  = OBJ_OFFSET_DEF
) (
   input  logic        rst,
   input  logic        clk,
   input  logic        scr1_cs,
   input  logic        scr2_cs,
   input  logic        obj_cs,
   input  logic [16:0] scr1_addr,
   input  logic [17:0] scr2_addr,
   input  logic [17:0] obj_addr,
   output logic        scr1_ok,
   output logic        scr2_ok,
   output logic        obj_ok,
   output logic [31:0] scr1_data,
   output logic [31:0] scr2_data,
   output logic [31:0] obj_data,
   output logic        mem_req,
   output logic [21:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_valid,
   input  logic [31:0] mem_data
);

   state_e      st_q, st_d;
   src_e        win_q, win_d;
   src_e        ptr_q, ptr_d;
   src_e        pick;
   logic        mem_req_q, mem_req_d;
   logic [21:0] mem_addr_q, mem_addr_d;
   logic [2:0]  miss;
   logic [2:0]  fill;

   // The latched tag is recovered from mem_addr by removing the offset; this is
   // exact because every requester address is narrower than the 22-bit bus.
   jtvigil_rom_cache #(.AW(17)) u_scr1 (
      .clk(clk), .rst(rst), .cs(scr1_cs), .addr(scr1_addr), .fill(fill[SRC_SCR1]),
      .fill_tag(17'(mem_addr_q - SCR1_OFFSET)), .fill_data(mem_data),
      .ok(scr1_ok), .miss(miss[SRC_SCR1]), .data(scr1_data)
   );

   jtvigil_rom_cache #(.AW(18)) u_scr2 (
      .clk(clk), .rst(rst), .cs(scr2_cs), .addr(scr2_addr), .fill(fill[SRC_SCR2]),
      .fill_tag(18'(mem_addr_q - SCR2_OFFSET)), .fill_data(mem_data),
      .ok(scr2_ok), .miss(miss[SRC_SCR2]), .data(scr2_data)
   );

   jtvigil_rom_cache #(.AW(18)) u_obj (
      .clk(clk), .rst(rst), .cs(obj_cs), .addr(obj_addr), .fill(fill[SRC_OBJ]),
      .fill_tag(18'(mem_addr_q - OBJ_OFFSET)), .fill_data(mem_data),
      .ok(obj_ok), .miss(miss[SRC_OBJ]), .data(obj_data)
   );

   always_comb begin
      st_d       = st_q;
      win_d      = win_q;
      ptr_d      = ptr_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      fill       = '0;
      pick       = rr_pick(miss, ptr_q);
      case (st_q)
         ST_IDLE: begin
            if (|miss) begin
               win_d     = pick;
               ptr_d     = src_next(pick);
               mem_req_d = 1'b1;
               st_d      = ST_REQ;
               case (pick)
                  SRC_SCR1: mem_addr_d = {5'd0, scr1_addr} + SCR1_OFFSET;
                  SRC_SCR2: mem_addr_d = {4'd0, scr2_addr} + SCR2_OFFSET;
                  default:  mem_addr_d = {4'd0, obj_addr}  + OBJ_OFFSET;
               endcase
            end
         end
         ST_REQ: begin
            if (mem_gnt) begin
               mem_req_d = 1'b0;
               if (mem_valid) begin
                  fill[win_q] = 1'b1;
                  st_d        = ST_IDLE;
               end else begin
                  st_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (mem_valid) begin
               fill[win_q] = 1'b1;
               st_d        = ST_IDLE;
            end
         end
         default: st_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q       <= ST_IDLE;
         win_q      <= SRC_SCR1;
         ptr_q      <= SRC_SCR1;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         st_q       <= st_d;
         win_q      <= win_d;
         ptr_q      <= ptr_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_jtvigil_rom_arb.sv
// Self-checking bench for jtvigil_rom_arb: directed scenarios followed by
// randomized traffic, all checked against a transaction-level cache model.
module tb_jtvigil_rom_arb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        scr1_cs = 1'b0, scr2_cs = 1'b0, obj_cs = 1'b0;
   logic [16:0] scr1_addr = '0;
   logic [17:0] scr2_addr = '0, obj_addr = '0;
   logic        mem_gnt = 1'b0, mem_valid = 1'b0;
   logic [31:0] mem_data = '0;

   logic        scr1_ok, scr2_ok, obj_ok, mem_req;
   logic [31:0] scr1_data, scr2_data, obj_data;
   logic [21:0] mem_addr;
   logic        w_scr1_ok, w_scr2_ok, w_obj_ok, w_mem_req;
   logic [31:0] w_scr1_data, w_scr2_data, w_obj_data;
   logic [21:0] w_mem_addr;

   always #5 clk = ~clk;

   jtvigil_rom_arb u_dut (
      .rst(rst), .clk(clk),
      .scr1_cs(scr1_cs), .scr2_cs(scr2_cs), .obj_cs(obj_cs),
      .scr1_addr(scr1_addr), .scr2_addr(scr2_addr), .obj_addr(obj_addr),
      .scr1_ok(scr1_ok), .scr2_ok(scr2_ok), .obj_ok(obj_ok),
      .scr1_data(scr1_data), .scr2_data(scr2_data), .obj_data(obj_data),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_gnt(mem_gnt), .mem_valid(mem_valid), .mem_data(mem_data)
   );

   // Same stimulus, relocated obj region that wraps past 2^22.
   jtvigil_rom_arb #(.OBJ_OFFSET(22'h3F0000)) u_wrap (
      .rst(rst), .clk(clk),
      .scr1_cs(scr1_cs), .scr2_cs(scr2_cs), .obj_cs(obj_cs),
      .scr1_addr(scr1_addr), .scr2_addr(scr2_addr), .obj_addr(obj_addr),
      .scr1_ok(w_scr1_ok), .scr2_ok(w_scr2_ok), .obj_ok(w_obj_ok),
      .scr1_data(w_scr1_data), .scr2_data(w_scr2_data), .obj_data(w_obj_data),
      .mem_req(w_mem_req), .mem_addr(w_mem_addr),
      .mem_gnt(mem_gnt), .mem_valid(mem_valid), .mem_data(mem_data)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: per-requester cache plus one outstanding transaction.
   logic        mv[3];
   logic [17:0] mt[3];
   logic [31:0] md[3];
   logic [21:0] offm[3] = '{22'h00000, 22'h08000, 22'h10000};
   logic [21:0] offw[3] = '{22'h00000, 22'h08000, 22'h3F0000};
   bit          busy, granted, exp_req;
   int          win, ptr;
   logic [17:0] lt;
   logic [21:0] exp_addr, wexp_addr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic cs_of(input int r);
      return (r == 0) ? scr1_cs : (r == 1) ? scr2_cs : obj_cs;
   endfunction

   function automatic logic [17:0] addr_of(input int r);
      return (r == 0) ? {1'b0, scr1_addr} : (r == 1) ? scr2_addr : obj_addr;
   endfunction

   function automatic logic ok_of(input int r);
      return (r == 0) ? scr1_ok : (r == 1) ? scr2_ok : obj_ok;
   endfunction

   function automatic logic [31:0] data_of(input int r);
      return (r == 0) ? scr1_data : (r == 1) ? scr2_data : obj_data;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 3; r++) begin
         mv[r] = 1'b0;
         mt[r] = '0;
         md[r] = '0;
      end
      busy = 0; granted = 0; exp_req = 0;
      win = 0; ptr = 0; lt = '0;
      exp_addr = '0; wexp_addr = '0;
   endtask

   task automatic model_fill();
      mv[win] = 1'b1;
      mt[win] = lt;
      md[win] = mem_data;
      busy    = 0;
   endtask

   // Effect of the coming clock edge given the inputs now being driven.
   task automatic model_update();
      logic [2:0] pend;
      if (!busy) begin
         for (int r = 0; r < 3; r++)
            pend[r] = cs_of(r) && !(mv[r] && mt[r] == addr_of(r));
         if (pend != 3'b000) begin
            win = ptr;
            for (int k = 0; k < 3; k++)
               if (!pend[win]) win = (win + 1) % 3;
            busy      = 1;
            granted   = 0;
            exp_req   = 1;
            lt        = addr_of(win);
            exp_addr  = 22'(addr_of(win)) + offm[win];
            wexp_addr = 22'(addr_of(win)) + offw[win];
            ptr       = (win + 1) % 3;
         end
      end else if (!granted) begin
         if (mem_gnt) begin
            exp_req = 0;
            if (mem_valid) model_fill();
            else granted = 1;
         end
      end else if (mem_valid) begin
         model_fill();
      end
   endtask

   task automatic model_check();
      for (int r = 0; r < 3; r++) begin
         logic eok;
         eok = cs_of(r) && mv[r] && (mt[r] == addr_of(r));
         chk($sformatf("ok%0d", r), ok_of(r), eok);
         if (eok) chk($sformatf("data%0d", r), data_of(r), md[r]);
      end
      chk("mem_req", mem_req, exp_req);
      chk("w_mem_req", w_mem_req, exp_req);
      if (exp_req) begin
         chk("mem_addr", mem_addr, exp_addr);
         chk("w_mem_addr", w_mem_addr, wexp_addr);
      end
   endtask

   task automatic step(input logic g, input logic v, input logic [31:0] d);
      mem_gnt   = g;
      mem_valid = v;
      mem_data  = d;
      model_update();
      @(posedge clk);
      @(negedge clk);
      mem_gnt   = 1'b0;
      mem_valid = 1'b0;
      model_check();
   endtask

   task automatic access(input logic [21:0] ea, input logic [31:0] d);
      step(1'b0, 1'b0, '0);
      chk("acc_req", mem_req, 1'b1);
      chk("acc_addr", mem_addr, ea);
      step(1'b1, 1'b0, '0);
      step(1'b0, 1'b1, d);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_ok", {scr1_ok, scr2_ok, obj_ok}, 3'b000);
      chk("rst_data", {scr1_data, scr2_data}, 64'd0);
      chk("rst_obj_data", obj_data, 32'd0);
      chk("rst_req", mem_req, 1'b0);
      chk("rst_addr", mem_addr, 22'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      do_reset();

      // Single miss, then hit.
      scr2_cs = 1'b1; scr2_addr = 18'h00010;
      step(1'b0, 1'b0, '0);
      chk("miss_req", mem_req, 1'b1);
      chk("miss_addr", mem_addr, 22'h08010);
      chk("miss_ok1", scr2_ok, 1'b0);
      step(1'b1, 1'b0, '0);
      chk("miss_ok2", scr2_ok, 1'b0);
      step(1'b0, 1'b1, 32'hCAFEBABE);
      chk("miss_ok3", scr2_ok, 1'b1);
      chk("miss_data", scr2_data, 32'hCAFEBABE);
      step(1'b0, 1'b0, '0);
      chk("hit_ok", scr2_ok, 1'b1);
      chk("hit_req", mem_req, 1'b0);
      scr2_cs = 1'b0;
      step(1'b0, 1'b0, '0);
      chk("cs_low_ok", scr2_ok, 1'b0);

      // Contention from reset, then a round starting after scr2.
      do_reset();
      scr1_cs = 1'b1; scr1_addr = 17'h00100;
      scr2_cs = 1'b1; scr2_addr = 18'h00200;
      obj_cs  = 1'b1; obj_addr  = 18'h00300;
      access(22'h00100, 32'h11111111);
      access(22'h08200, 32'h22222222);
      access(22'h10300, 32'h33333333);
      chk("rr_all_ok", {scr1_ok, scr2_ok, obj_ok}, 3'b111);
      chk("rr_scr1_data", scr1_data, 32'h11111111);
      scr1_cs = 1'b0; obj_cs = 1'b0; scr2_addr = 18'h00204;
      access(22'h08204, 32'h44444444);
      scr1_cs = 1'b1; scr1_addr = 17'h00104;
      obj_cs  = 1'b1; obj_addr  = 18'h00304;
      scr2_addr = 18'h00208;
      access(22'h10304, 32'h55555555);
      access(22'h00104, 32'h66666666);
      access(22'h08208, 32'h77777777);
      scr1_cs = 1'b0; scr2_cs = 1'b0; obj_cs = 1'b0;

      // Address change while waiting for data.
      scr1_cs = 1'b1; scr1_addr = 17'h00004;
      step(1'b0, 1'b0, '0);
      chk("chg_addr", mem_addr, 22'h00004);
      step(1'b1, 1'b0, '0);
      scr1_addr = 17'h00008;
      step(1'b0, 1'b1, 32'hA5A5A5A5);
      chk("chg_ok_low", scr1_ok, 1'b0);
      scr1_addr = 17'h00004;
      #1;
      chk("chg_tag_kept", scr1_ok, 1'b1);
      chk("chg_tag_data", scr1_data, 32'hA5A5A5A5);
      scr1_addr = 17'h00008;
      #1;
      access(22'h00008, 32'h5A5A5A5A);
      chk("chg_new_ok", scr1_ok, 1'b1);
      scr1_cs = 1'b0;

      // Reset during WAIT, then a late valid.
      scr2_cs = 1'b1; scr2_addr = 18'h00400;
      step(1'b0, 1'b0, '0);
      step(1'b1, 1'b0, '0);
      scr2_cs = 1'b0;
      do_reset();
      step(1'b0, 1'b1, 32'h12345678);
      chk("late_req", mem_req, 1'b0);
      chk("late_ok", {scr1_ok, scr2_ok, obj_ok}, 3'b000);
      scr2_cs = 1'b1;
      #1;
      chk("late_no_valid", scr2_ok, 1'b0);
      scr2_cs = 1'b0;
      #1;

      // Offset wrap, with gnt and valid together.
      obj_cs = 1'b1; obj_addr = 18'h3FFFF;
      step(1'b0, 1'b0, '0);
      chk("wrap_addr", w_mem_addr, 22'h02FFFF);
      chk("wrap_main_addr", mem_addr, 22'h04FFFF);
      step(1'b1, 1'b1, 32'hDEADBEEF);
      chk("gv_ok", obj_ok, 1'b1);
      chk("gv_req", mem_req, 1'b0);
      obj_cs = 1'b0;

      // Random traffic over a small address set to mix hits and misses.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3) == 0) scr1_cs = 1'($urandom_range(1));
         if ($urandom_range(3) == 0) scr2_cs = 1'($urandom_range(1));
         if ($urandom_range(3) == 0) obj_cs  = 1'($urandom_range(1));
         if ($urandom_range(3) == 0) scr1_addr = 17'($urandom_range(3));
         if ($urandom_range(3) == 0) scr2_addr = 18'($urandom_range(3));
         if ($urandom_range(3) == 0) obj_addr  = 18'($urandom_range(3));
         step(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/jtvigil_rom_arb.md
JTVIGIL_ROM_ARB -- requirements
Module: jtvigil_rom_arb

Interface
REQ-001 Parameter SCR1_OFFSET, default 22'h00000: word offset added to scr1 addresses.
REQ-002 Parameter SCR2_OFFSET, default 22'h08000: word offset added to scr2 addresses.
REQ-003 Parameter OBJ_OFFSET, default 22'h10000: word offset added to obj addresses.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port clk, input, 1: the block's single clock, 48 MHz.
REQ-006 Ports scr1_cs/scr2_cs/obj_cs, input, 1 each: requester wants data at its addr.
REQ-007 Ports scr1_addr (17), scr2_addr (18), obj_addr (18), input: 32-bit word addresses.
REQ-008 Ports scr1_ok/scr2_ok/obj_ok, output, 1 each: data output valid for the current addr.
REQ-009 Ports scr1_data/scr2_data/obj_data, output, 32 each: returned words.
REQ-010 Port mem_req, output, 1: memory request pending.
REQ-011 Port mem_addr, output, 22: requester address zero-extended plus its OFFSET, modulo 2^22.
REQ-012 Port mem_gnt, input, 1: one-cycle pulse; request accepted.
REQ-013 Port mem_valid, input, 1: one-cycle pulse; mem_data holds the accepted word.
REQ-014 Port mem_data, input, 32: memory read data.

Function
REQ-015 Each requester SHALL own a one-entry cache: tag = address, data word, valid bit.
REQ-016 ok SHALL be combinational: cs AND valid AND (tag == addr); it never asserts with cs low.
REQ-017 A requester is pending when cs=1 and its cache misses.
REQ-018 FSM states SHALL be IDLE, REQ and WAIT.
REQ-019 IDLE: with any requester pending, latch the winner and its address, set mem_req, go to REQ.
REQ-020 Arbitration SHALL be round-robin, order scr1 -> scr2 -> obj; search starts after the last winner; after reset it starts at scr1.
REQ-021 REQ: hold mem_req and mem_addr stable until mem_gnt; on mem_gnt drop mem_req and go to WAIT.
REQ-022 WAIT: on mem_valid write mem_data and the latched tag into the winner's cache, set valid, go to IDLE.
REQ-023 The FSM SHALL return to IDLE no earlier than the cycle after mem_valid, so at most one access is outstanding.
REQ-024 Latency on a miss with immediate gnt and valid one cycle later: ok rises 3 clk after the cs/addr change.
REQ-025 A cs drop or addr change in REQ/WAIT SHALL NOT abort the access; the word fills the cache under the latched tag, and ok stays low while addr differs from that tag.
REQ-026 mem_gnt or mem_valid arriving in a state other than REQ or WAIT respectively SHALL be ignored.
REQ-027 If mem_gnt and mem_valid arrive in the same REQ cycle, the word SHALL be taken and the FSM goes to IDLE.
REQ-028 Cache data SHALL hold its value until the next fill for that requester.

Reset
REQ-029 On rst: FSM=IDLE, mem_req=0, mem_addr=0, all valid=0, all ok=0, all data outputs=0, round-robin pointer=scr1.
REQ-030 rst asserted mid-access SHALL discard the access; after release, a mem_valid from it is ignored (REQ-026).

Structure
REQ-031 The offset defaults and the FSM state encoding SHALL live in a shared package jtvigil_pkg.
REQ-032 The per-requester cache SHALL be one sub-module, jtvigil_rom_cache, instantiated three times with address width as a parameter.

Verification
REQ-033 Single miss: scr2_cs=1, scr2_addr=18'h00010, gnt next cycle, valid one cycle later with 32'hCAFEBABE -> mem_addr=22'h08010, scr2_ok=1 with that data 3 clk after the request.
REQ-034 Hit: repeat scr2_addr=18'h00010 -> scr2_ok=1 in the same cycle, mem_req stays 0.
REQ-035 Contention: all three cs rise together on misses -> service order scr1, scr2, obj; a second round after scr2 wins starts at obj.
REQ-036 Address change in WAIT: scr1 addr 17'h00004 changes to 17'h00008 -> ok stays low, cache tag 17'h00004, then a new access for 17'h00008.
REQ-037 Reset mid-WAIT, then late mem_valid -> no valid bit set, all ok=0, mem_req=0.
REQ-038 Offset wrap: obj_addr=18'h3FFFF with OBJ_OFFSET=22'h3F0000 -> mem_addr=22'h02FFFF.
